// File: rtl/msrh_inst_buffer.sv
// msrh_inst_buffer: instruction buffer behind the I-cache S2 response.
// Holds whole fetched lines in a small FIFO and hands decode up to
// DISP_SIZE consecutive 32-bit instructions per cycle.
// Optional feature: define MSRH_IBUF_BYPASS_EN to let a line arriving at an
// empty buffer drive the dispatch window in the same cycle.
module msrh_inst_buffer #(
  parameter int DATA_W    = 256,
  parameter int VADDR_W   = 39,
  parameter int DEPTH     = 4,
  parameter int DISP_SIZE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_s2_valid,
  input  logic [VADDR_W-1:0]      i_s2_vaddr,
  input  logic [DATA_W-1:0]       i_s2_data,
  input  logic [DATA_W/8-1:0]     i_s2_be,
  output logic                    o_s2_ready,
  input  logic                    i_flush,
  output logic                    o_disp_valid,
  output logic [VADDR_W-1:0]      o_disp_pc,
  output logic [DISP_SIZE*32-1:0] o_disp_inst,
  output logic [DISP_SIZE-1:0]    o_disp_mask,
  input  logic                    i_disp_ready
);

  localparam int INSTS    = DATA_W / 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int LINE_LSB = $clog2(BE_W);
  localparam int OFS_W    = $clog2(INSTS);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  // Line storage; only the head entry is ever read.
  logic [VADDR_W-1:0] vaddr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem  [DEPTH];
  logic [BE_W-1:0]    be_mem    [DEPTH];
  logic [OFS_W-1:0]   ofs_mem   [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic               s2_ready, push, head_valid, use_bypass;
  logic [VADDR_W-1:0] in_line_vaddr;
  logic [OFS_W-1:0]   in_ofs;

  logic               win_valid;
  logic [VADDR_W-1:0] win_vaddr;
  logic [DATA_W-1:0]  win_data;
  logic [BE_W-1:0]    win_be;
  logic [OFS_W-1:0]   win_ofs;

  logic [DISP_SIZE-1:0]    lane_ok;
  logic [DISP_SIZE*32-1:0] lane_inst;
  logic [DISP_SIZE-1:0]    mask;
  logic [OFS_W:0]          pop_cnt;
  logic [OFS_W:0]          new_ofs_full;
  logic [OFS_W-1:0]        new_ofs, write_ofs;
  logic                    disp_valid, fire, dead, retire;
  logic                    write_en, pop_head, upd_en;

  // Ready depends only on the registered occupancy, never on a same-cycle pop.
  assign s2_ready      = (count_reg != CNT_W'(DEPTH));
  assign push          = i_s2_valid & s2_ready & ~i_flush;
  assign head_valid    = (count_reg != '0);
  assign in_line_vaddr = i_s2_vaddr & ~VADDR_W'(BE_W - 1);
  assign in_ofs        = i_s2_vaddr[LINE_LSB-1:2];

`ifdef MSRH_IBUF_BYPASS_EN
  // An empty buffer lets the incoming line drive the window directly.
  assign use_bypass = (count_reg == '0) & push;
  assign win_valid  = head_valid | use_bypass;
  assign win_vaddr  = use_bypass ? in_line_vaddr : vaddr_mem[head_reg];
  assign win_data   = use_bypass ? i_s2_data     : data_mem[head_reg];
  assign win_be     = use_bypass ? i_s2_be       : be_mem[head_reg];
  assign win_ofs    = use_bypass ? in_ofs        : ofs_mem[head_reg];
`else
  assign use_bypass = 1'b0;
  assign win_valid  = head_valid;
  assign win_vaddr  = vaddr_mem[head_reg];
  assign win_data   = data_mem[head_reg];
  assign win_be     = be_mem[head_reg];
  assign win_ofs    = ofs_mem[head_reg];
`endif

  // Per-lane instruction select and byte-enable qualification.
  generate
    for (genvar gi = 0; gi < DISP_SIZE; gi++) begin : g_lane
      logic [OFS_W:0] idx;
      logic           ok_l;
      logic [31:0]    inst_l;
      assign idx = {1'b0, win_ofs} + (OFS_W + 1)'(gi);
      // Lane is usable only when its instruction lies inside the line and is fully enabled.
      always_comb begin
        ok_l   = 1'b0;
        inst_l = '0;
        for (int k = 0; k < INSTS; k++) begin
          if (idx == (OFS_W + 1)'(k)) begin
            ok_l   = &win_be[4*k +: 4];
            inst_l = win_data[32*k +: 32];
          end
        end
      end
      assign lane_ok[gi]           = ok_l;
      assign lane_inst[32*gi +: 32] = inst_l;
    end
  endgenerate

  // Prefix mask so dispatched lanes are always contiguous from lane 0, plus its population.
  always_comb begin
    logic run;
    run     = win_valid;
    pop_cnt = '0;
    mask    = '0;
    for (int i = 0; i < DISP_SIZE; i++) begin
      run     = run & lane_ok[i];
      mask[i] = run;
      pop_cnt = pop_cnt + {{OFS_W{1'b0}}, run};
    end
  end

  assign disp_valid   = mask[0];
  assign fire         = disp_valid & i_disp_ready & ~i_flush;
  assign new_ofs_full = {1'b0, win_ofs} + pop_cnt;
  assign new_ofs      = new_ofs_full[OFS_W-1:0];
  // A head whose first lane is unusable can never dispatch, so it is dropped.
  assign dead         = win_valid & ~lane_ok[0];
  assign retire       = dead | (fire & (new_ofs_full >= (OFS_W + 1)'(INSTS)));
  // A bypassed line that was fully used (or dead) never needs storing.
  assign write_en     = push & ~(use_bypass & retire);
  assign pop_head     = retire & head_valid & ~use_bypass & ~i_flush;
  assign upd_en       = fire & ~retire & ~use_bypass;
  assign write_ofs    = (use_bypass & fire) ? new_ofs : in_ofs;

  // Pointer and occupancy state; flush empties the buffer outright.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (i_flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PTR_W'(pop_head);
      tail_reg  <= tail_reg + PTR_W'(write_en);
      count_reg <= count_reg + CNT_W'(write_en) - CNT_W'(pop_head);
    end
  end

  // Line storage writes: new line at tail, partial-consume offset update at head.
  always_ff @(posedge i_clk) begin
    if (write_en) begin
      vaddr_mem[tail_reg] <= in_line_vaddr;
      data_mem[tail_reg]  <= i_s2_data;
      be_mem[tail_reg]    <= i_s2_be;
      ofs_mem[tail_reg]   <= write_ofs;
    end
    if (upd_en) begin
      ofs_mem[head_reg] <= new_ofs;
    end
  end

  assign o_s2_ready   = s2_ready;
  assign o_disp_valid = disp_valid;
  assign o_disp_mask  = mask;
  assign o_disp_pc    = win_valid ? (win_vaddr + VADDR_W'({win_ofs, 2'b00})) : '0;
  assign o_disp_inst  = win_valid ? lane_inst : '0;

endmodule

// File: tb/tb_msrh_inst_buffer.sv
// Testbench for msrh_inst_buffer: directed scenarios plus random traffic,
// checked each cycle against a queue-of-lines reference model.
module tb_msrh_inst_buffer;

  localparam int DATA_W    = 256;
  localparam int VADDR_W   = 39;
  localparam int DEPTH     = 4;
  localparam int DISP_SIZE = 4;
  localparam int INSTS     = DATA_W / 32;

  logic                    i_clk;
  logic                    i_reset_n;
  logic                    i_s2_valid;
  logic [VADDR_W-1:0]      i_s2_vaddr;
  logic [DATA_W-1:0]       i_s2_data;
  logic [DATA_W/8-1:0]     i_s2_be;
  logic                    o_s2_ready;
  logic                    i_flush;
  logic                    o_disp_valid;
  logic [VADDR_W-1:0]      o_disp_pc;
  logic [DISP_SIZE*32-1:0] o_disp_inst;
  logic [DISP_SIZE-1:0]    o_disp_mask;
  logic                    i_disp_ready;

  msrh_inst_buffer #(
    .DATA_W(DATA_W), .VADDR_W(VADDR_W), .DEPTH(DEPTH), .DISP_SIZE(DISP_SIZE)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_s2_valid(i_s2_valid), .i_s2_vaddr(i_s2_vaddr), .i_s2_data(i_s2_data),
    .i_s2_be(i_s2_be), .o_s2_ready(o_s2_ready), .i_flush(i_flush),
    .o_disp_valid(o_disp_valid), .o_disp_pc(o_disp_pc), .o_disp_inst(o_disp_inst),
    .o_disp_mask(o_disp_mask), .i_disp_ready(i_disp_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [VADDR_W-1:0] va;
    logic [DATA_W-1:0]  data;
    logic [31:0]        be;
    int                 ofs;
  } line_t;

  line_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of consecutive fully-enabled instructions from the line offset, capped at the lane count.
  function automatic int avail(input line_t e);
    int n = 0;
    while (n < DISP_SIZE && (e.ofs + n) < INSTS && e.be[4*(e.ofs+n) +: 4] == 4'hF) n++;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] mkdata(input int base);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < INSTS; k++) d[32*k +: 32] = 32'(base + k);
    return d;
  endfunction

  task automatic model_check();
    int n;
    logic [DISP_SIZE*32-1:0] exp_inst, lmask;
    line_t h;
    n = 0;
    if (q.size() > 0) begin
      h = q[0];
      n = avail(h);
    end
    check("s2_ready", 256'(o_s2_ready), 256'(q.size() != DEPTH));
    check("disp_valid", 256'(o_disp_valid), 256'(n > 0));
    check("disp_mask", 256'(o_disp_mask), 256'((1 << n) - 1));
    if (n > 0) begin
      exp_inst = '0;
      lmask    = '0;
      for (int i = 0; i < n; i++) begin
        exp_inst[32*i +: 32] = h.data[32*(h.ofs+i) +: 32];
        lmask[32*i +: 32]    = 32'hFFFF_FFFF;
      end
      check("disp_pc", 256'(o_disp_pc), 256'(h.va + VADDR_W'(4 * h.ofs)));
      check("disp_inst", 256'(o_disp_inst & lmask), 256'(exp_inst));
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [VADDR_W-1:0] va, input logic [DATA_W-1:0] d,
                       input logic [31:0] be, input logic rdy, input logic fl);
    int sz0, n;
    line_t h, nl;
    i_s2_valid = v; i_s2_vaddr = va; i_s2_data = d; i_s2_be = be;
    i_disp_ready = rdy; i_flush = fl;
    @(negedge i_clk);
    model_check();
    @(posedge i_clk);
    if (fl) begin
      q.delete();
    end else begin
      sz0 = q.size();
      if (sz0 > 0) begin
        h = q[0];
        n = avail(h);
        if (n == 0) void'(q.pop_front());
        else if (rdy) begin
          h.ofs += n;
          if (h.ofs >= INSTS) void'(q.pop_front());
          else q[0] = h;
        end
      end
      if (v && sz0 != DEPTH) begin
        nl.va   = va & ~VADDR_W'(31);
        nl.data = d;
        nl.be   = be;
        nl.ofs  = int'(va[4:2]);
        q.push_back(nl);
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic push(input logic [VADDR_W-1:0] va, input int base, input logic [31:0] be, input logic rdy);
    cycle(1'b1, va, mkdata(base), be, rdy, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] m, input logic [VADDR_W-1:0] pc);
    check({tag, "_valid"}, 256'(o_disp_valid), 256'(v));
    check({tag, "_mask"}, 256'(o_disp_mask), 256'(m));
    if (v) check({tag, "_pc"}, 256'(o_disp_pc), 256'(pc));
  endtask

  task automatic drain();
    repeat (12) idle(1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [31:0]       rbe;
    logic [VADDR_W-1:0] rva;
    int r;
    i_reset_n = 1'b0; i_s2_valid = 1'b0; i_s2_vaddr = '0; i_s2_data = '0;
    i_s2_be = '0; i_flush = 1'b0; i_disp_ready = 1'b0;
    #2;
    check("rst_valid", 256'(o_disp_valid), 256'(0));
    check("rst_mask", 256'(o_disp_mask), 256'(0));
    check("rst_pc", 256'(o_disp_pc), 256'(0));
    check("rst_inst", 256'(o_disp_inst), 256'(0));
    check("rst_ready", 256'(o_s2_ready), 256'(1));
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Aligned line dispatched in two groups of four.
    push(39'h80_0000_00, 32'h100, 32'hFFFF_FFFF, 1'b1);
    expect_out("t1a", 1'b1, 4'hF, 39'h80_0000_00);
    check("t1a_inst", 256'(o_disp_inst), 256'(128'h00000103_00000102_00000101_00000100));
    idle(1'b1);
    expect_out("t1b", 1'b1, 4'hF, 39'h80_0000_10);
    check("t1b_inst", 256'(o_disp_inst), 256'(128'h00000107_00000106_00000105_00000104));
    idle(1'b1);
    expect_out("t1c", 1'b0, 4'h0, '0);
    check("t1c_ready", 256'(o_s2_ready), 256'(1));

    // Start offset 6: only two lanes remain in the line.
    push(39'h80_0000_18, 32'h100, 32'hFFFF_FFFF, 1'b1);
    expect_out("t2a", 1'b1, 4'h3, 39'h80_0000_18);
    check("t2a_inst", 256'(o_disp_inst[63:0]), 256'(64'h00000107_00000106));
    idle(1'b1);
    expect_out("t2b", 1'b0, 4'h0, '0);

    // Fill the buffer with decode stalled, then release it.
    for (int i = 0; i < 4; i++) push(39'h80_0001_00 + 39'(32 * i), 32'h200 + 16 * i, 32'hFFFF_FFFF, 1'b0);
    check("t3_full", 256'(o_s2_ready), 256'(0));
    push(39'h80_0002_00, 32'h300, 32'hFFFF_FFFF, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t3_ready", 256'(o_s2_ready), 256'(1));
    expect_out("t3", 1'b1, 4'hF, 39'h80_0001_20);
    drain();

    // Partial byte enables: two lanes, then a dead head that is dropped.
    push(39'h80_0003_00, 32'h400, 32'hFFFF_F0FF, 1'b0);
    expect_out("t4a", 1'b1, 4'h3, 39'h80_0003_00);
    push(39'h80_0004_00, 32'h500, 32'hFFFF_FFFF, 1'b1);
    expect_out("t4b", 1'b0, 4'h0, '0);
    idle(1'b0);
    expect_out("t4c", 1'b1, 4'hF, 39'h80_0004_00);
    drain();

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) push(39'h80_0005_00 + 39'(32 * i), 32'h600, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, 39'h80_0006_00, mkdata(32'h700), 32'hFFFF_FFFF, 1'b1, 1'b1);
    expect_out("t5a", 1'b0, 4'h0, '0);
    check("t5a_ready", 256'(o_s2_ready), 256'(1));
    push(39'h80_0010_00, 32'h800, 32'hFFFF_FFFF, 1'b1);
    expect_out("t5b", 1'b1, 4'hF, 39'h80_0010_00);
    drain();

    // Reset pulse with two entries queued.
    push(39'h80_0020_00, 32'h900, 32'hFFFF_FFFF, 1'b0);
    push(39'h80_0020_20, 32'h910, 32'hFFFF_FFFF, 1'b0);
    i_s2_valid = 1'b0; i_disp_ready = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check("t6_valid", 256'(o_disp_valid), 256'(0));
    check("t6_mask", 256'(o_disp_mask), 256'(0));
    check("t6_pc", 256'(o_disp_pc), 256'(0));
    check("t6_ready", 256'(o_s2_ready), 256'(1));
    q.delete();
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    push(39'h80_0030_08, 32'hA00, 32'hFFFF_FFFF, 1'b1);
    expect_out("t6b", 1'b1, 4'hF, 39'h80_0030_08);
    drain();

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < INSTS; k++) rd[32*k +: 32] = $urandom;
      rva = 39'h40_0000_0000 | (39'($urandom) & ~39'h3);
      r = int'($urandom_range(0, 9));
      if (r < 7) rbe = 32'hFFFF_FFFF;
      else if (r < 9) rbe = ~(32'hF << (4 * $urandom_range(0, INSTS - 1)));
      else rbe = $urandom;
      cycle(1'($urandom_range(0, 1)), rva, rd, rbe,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
